// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO between core stores and data memory.
// Define STORE_BUF_MERGE_EN to merge same-doubleword stores into the youngest entry.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 64,
    parameter int DW    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid,
    input  logic [AW-1:0]   st_addr,
    input  logic [DW-1:0]   st_data,
    output logic            st_stall,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data,
    output logic [DW/8-1:0] mem_strb,
    input  logic            mem_ready,
    output logic            empty,
    output logic            full,
    output logic            misalign
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          enq;
    logic          deq;
    logic          merge;

`ifdef STORE_BUF_MERGE_EN
    logic [PW-1:0] last;

    // count >= 2 keeps the youngest entry distinct from the offered head
    assign last  = tail - PW'(1);
    assign merge = st_valid && (count >= (PW+1)'(2))
                && (st_addr[AW-1:3] == addr_q[last][AW-1:3]);
`else
    assign merge = 1'b0;
`endif

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign st_stall  = st_valid && full && !merge;
    assign enq       = st_valid && !full && !merge;
    assign mem_valid = !empty;
    assign deq       = mem_valid && mem_ready;

    assign mem_addr = {addr_q[head][AW-1:3], 3'b000};
    assign mem_data = data_q[head];
    assign mem_strb = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            unique case ({enq, deq})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if ((enq || merge) && (st_addr[2:0] != 3'b000)) begin
                misalign <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= st_addr;
            data_q[tail] <= st_data;
        end
`ifdef STORE_BUF_MERGE_EN
        if (!rst && merge) begin
            data_q[last] <= st_data;
        end
`endif
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, then random
// traffic compared against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUF_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_stall;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_data;
    logic [7:0]  mem_strb;
    logic        mem_ready;
    logic        empty;
    logic        full;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(64), .DW(64)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_stall(st_stall),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_strb(mem_strb), .mem_ready(mem_ready),
        .empty(empty), .full(full), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [63:0] a;
        logic [63:0] d;
        logic        rdy;
        logic        mv;
        logic [63:0] ma;
        logic [63:0] md;
        logic        stall;
        logic        emp;
        logic        ful;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    vec_t tbl[$];
    ent_t q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic v, input logic [63:0] a,
        input logic [63:0] d, input logic rdy, input logic mv,
        input logic [63:0] ma, input logic [63:0] md, input logic stall,
        input logic emp, input logic ful, input logic mis);
        vec_t x;
        x.r = r; x.v = v; x.a = a; x.d = d; x.rdy = rdy;
        x.mv = mv; x.ma = ma; x.md = md; x.stall = stall;
        x.emp = emp; x.ful = ful; x.mis = mis;
        return x;
    endfunction

    task automatic run_row(input vec_t x, input int idx);
        string t;
        rst = x.r; st_valid = x.v; st_addr = x.a;
        st_data = x.d; mem_ready = x.rdy;
        @(negedge clk);
        t = $sformatf("row%0d", idx);
        chk({t, ".mem_valid"}, 64'(mem_valid), 64'(x.mv));
        chk({t, ".st_stall"}, 64'(st_stall), 64'(x.stall));
        chk({t, ".empty"}, 64'(empty), 64'(x.emp));
        chk({t, ".full"}, 64'(full), 64'(x.ful));
        chk({t, ".misalign"}, 64'(misalign), 64'(x.mis));
        if (x.mv) begin
            chk({t, ".mem_addr"}, mem_addr, x.ma);
            chk({t, ".mem_data"}, mem_data, x.md);
            chk({t, ".mem_strb"}, 64'(mem_strb), 64'hFF);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a0;
        logic [63:0] mrg_d;
        bit          mis_m;
        bit          fl;
        bit          mc;
        bit          st;
        a0 = 64'h8000_0000;
        rst = 1'b1; st_valid = 1'b0; st_addr = '0;
        st_data = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // idle after reset
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,0));
        // single store, one cycle to offer
        tbl.push_back(mk(0,1,64'h8000_1000,64'hDEADBEEF_CAFEF00D,1,
                         0,0,0, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,64'h8000_1000,64'hDEADBEEF_CAFEF00D,
                         0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,0));
        // fill with memory blocked, fifth store stalls
        tbl.push_back(mk(0,1,a0,64'hA0,0, 0,0,0, 0,1,0,0));
        tbl.push_back(mk(0,1,a0+8,64'hA1,0, 1,a0,64'hA0, 0,0,0,0));
        tbl.push_back(mk(0,1,a0+16,64'hA2,0, 1,a0,64'hA0, 0,0,0,0));
        tbl.push_back(mk(0,1,a0+24,64'hA3,0, 1,a0,64'hA0, 0,0,0,0));
        tbl.push_back(mk(0,1,a0+32,64'hA4,0, 1,a0,64'hA0, 1,0,1,0));
        tbl.push_back(mk(0,1,a0+32,64'hA4,0, 1,a0,64'hA0, 1,0,1,0));
        // full plus handshake: store still stalls this cycle
        tbl.push_back(mk(0,1,a0+32,64'hA4,1, 1,a0,64'hA0, 1,0,1,0));
        tbl.push_back(mk(0,1,a0+32,64'hA4,1, 1,a0+8,64'hA1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,a0+16,64'hA2, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,a0+24,64'hA3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,a0+32,64'hA4, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,0));
        // count = 2 with simultaneous store and handshake
        tbl.push_back(mk(0,1,64'h100,64'h11,0, 0,0,0, 0,1,0,0));
        tbl.push_back(mk(0,1,64'h108,64'h12,0, 1,64'h100,64'h11, 0,0,0,0));
        tbl.push_back(mk(0,1,64'h110,64'h13,1, 1,64'h100,64'h11, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,64'h108,64'h12, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,64'h108,64'h12, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1, 1,64'h110,64'h13, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,0));
        // misaligned store, then reset mid-drain
        tbl.push_back(mk(0,1,a0+4,64'h55,0, 0,0,0, 0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,a0,64'h55, 0,0,0,1));
        tbl.push_back(mk(0,1,a0+16,64'h66,1, 1,a0,64'h55, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0, 1,a0+16,64'h66, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,0));
        // merge candidate: A, B, B+4 with memory blocked
        mrg_d = MERGE ? 64'h3 : 64'h2;
        tbl.push_back(mk(0,1,64'h100,64'h1,0, 0,0,0, 0,1,0,0));
        tbl.push_back(mk(0,1,64'h200,64'h2,0, 1,64'h100,64'h1, 0,0,0,0));
        tbl.push_back(mk(0,1,64'h204,64'h3,0, 1,64'h100,64'h1, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0, 1,64'h100,64'h1, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,64'h100,64'h1, 0,0,0,1));
        tbl.push_back(mk(0,0,0,0,1, 1,64'h200,mrg_d, 0,0,0,1));
        if (!MERGE) begin
            tbl.push_back(mk(0,0,0,0,1, 1,64'h200,64'h3, 0,0,0,1));
        end
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,1,0,1));

        foreach (tbl[i]) run_row(tbl[i], i);

        // random traffic against the queue model
        rst = 1'b1; st_valid = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        mis_m = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            st_valid  = ($urandom_range(0, 9) < 6);
            st_addr   = a0 + 64'($urandom_range(0, 3) * 8)
                      + (($urandom_range(0, 7) == 0) ? 64'd4 : 64'd0);
            st_data   = {$urandom, $urandom};
            mem_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            fl = (q.size() == DEPTH);
            mc = MERGE && st_valid && (q.size() >= 2)
              && (q[$].a[63:3] == st_addr[63:3]);
            st = st_valid && fl && !mc;
            chk("rnd.mem_valid", 64'(mem_valid), 64'(q.size() != 0));
            chk("rnd.empty", 64'(empty), 64'(q.size() == 0));
            chk("rnd.full", 64'(full), 64'(fl));
            chk("rnd.st_stall", 64'(st_stall), 64'(st));
            chk("rnd.misalign", 64'(misalign), 64'(mis_m));
            if (q.size() != 0) begin
                chk("rnd.mem_addr", mem_addr, {q[0].a[63:3], 3'b000});
                chk("rnd.mem_data", mem_data, q[0].d);
            end
            @(posedge clk);
            if (rst) begin
                q.delete();
                mis_m = 1'b0;
            end else begin
                if ((mc || (st_valid && !fl)) && st_addr[2:0] != 3'b000)
                    mis_m = 1'b1;
                if (mc) q[q.size()-1].d = st_data;
                if (q.size() != 0 && mem_ready) void'(q.pop_front());
                if (st_valid && !fl && !mc) begin
                    ent_t e;
                    e.a = st_addr;
                    e.d = st_data;
                    q.push_back(e);
                end
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
